// File: rtl/branch_resolve.sv
// branch_resolve: Execute-stage branch resolution and one-bit predictor update.
// Captures a predicted branch leaving Decode, resolves it against takenE in
// Execute, drives the predictor write, the mispredict redirect/squash and two
// saturating performance counters.
module branch_resolve #(
    parameter int AW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          branchD,
    input  logic          predD,
    input  logic [AW-1:0] pcD,
    input  logic [AW-1:0] pcplus4D,
    input  logic [AW-1:0] pcbranchD,
    input  logic          flushE,
    input  logic          takenE,
    output logic          weE,
    output logic [AW-1:0] waddrE,
    output logic          wdE,
    output logic          mispredictE,
    output logic [AW-1:0] redirectPcE,
    output logic          squashD,
    output logic [CW-1:0] branchCount,
    output logic [CW-1:0] mispredCount
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          validE;
    logic          predE;
    logic [AW-1:0] pcE;
    logic [AW-1:0] pcplus4E;
    logic [AW-1:0] pcbranchE;
    logic          capture;

    // A stalled branch stays in Decode (flushE) and a mispredict kills the
    // younger Decode instruction, so neither case may load the E registers.
    assign capture = branchD & ~flushE & ~mispredictE;

    // E-stage register set: valid bit follows capture, data holds otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            validE    <= 1'b0;
            predE     <= 1'b0;
            pcE       <= '0;
            pcplus4E  <= '0;
            pcbranchE <= '0;
        end else begin
            validE <= capture;
            if (capture) begin
                predE     <= predD;
                pcE       <= pcD;
                pcplus4E  <= pcplus4D;
                pcbranchE <= pcbranchD;
            end
        end
    end

    // Saturating counters; reset discards a branch sitting in Execute
    always_ff @(posedge clk) begin
        if (reset) begin
            branchCount  <= '0;
            mispredCount <= '0;
        end else begin
            if (validE && branchCount != CNT_MAX)
                branchCount <= branchCount + CNT_ONE;
            if (mispredictE && mispredCount != CNT_MAX)
                mispredCount <= mispredCount + CNT_ONE;
        end
    end

    // Resolution outputs, all combinational from the E registers and takenE
    always_comb begin
        weE         = validE;
        waddrE      = pcE;
        wdE         = takenE;
        mispredictE = validE & (predE ^ takenE);
        redirectPcE = takenE ? pcbranchE : pcplus4E;
        squashD     = mispredictE;
    end

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based behavioural model of the branch in Execute.
module tb_branch_resolve;

    localparam int AW = 32;

    logic          clk;
    logic          reset;
    logic          branchD;
    logic          predD;
    logic [AW-1:0] pcD;
    logic [AW-1:0] pcplus4D;
    logic [AW-1:0] pcbranchD;
    logic          flushE;
    logic          takenE;

    logic          weE, wdE, mispredictE, squashD;
    logic [AW-1:0] waddrE, redirectPcE;
    logic [15:0]   branchCount, mispredCount;

    logic          s_weE, s_wdE, s_mispredictE, s_squashD;
    logic [AW-1:0] s_waddrE, s_redirectPcE;
    logic [3:0]    s_branchCount, s_mispredCount;

    int vectors = 0;
    int miscompares = 0;

    // full-width counters
    branch_resolve #(.AW(AW), .CW(16)) dut (
        .clk(clk), .reset(reset), .branchD(branchD), .predD(predD), .pcD(pcD),
        .pcplus4D(pcplus4D), .pcbranchD(pcbranchD), .flushE(flushE), .takenE(takenE),
        .weE(weE), .waddrE(waddrE), .wdE(wdE), .mispredictE(mispredictE),
        .redirectPcE(redirectPcE), .squashD(squashD),
        .branchCount(branchCount), .mispredCount(mispredCount)
    );

    // 4-bit counters so saturation is reached quickly
    branch_resolve #(.AW(AW), .CW(4)) dut_s (
        .clk(clk), .reset(reset), .branchD(branchD), .predD(predD), .pcD(pcD),
        .pcplus4D(pcplus4D), .pcbranchD(pcbranchD), .flushE(flushE), .takenE(takenE),
        .weE(s_weE), .waddrE(s_waddrE), .wdE(s_wdE), .mispredictE(s_mispredictE),
        .redirectPcE(s_redirectPcE), .squashD(s_squashD),
        .branchCount(s_branchCount), .mispredCount(s_mispredCount)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          pred;
        logic [AW-1:0] pc;
        logic [AW-1:0] p4;
        logic [AW-1:0] pt;
    } br_t;

    br_t in_ex_q[$];        // branch currently resolving (0 or 1 entries)
    br_t last_br = '0;      // most recently captured branch, for held fields
    int  m_bc = 0;
    int  m_mc = 0;

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // Compare every cycle, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        logic    e_valid, e_misp;
        logic [AW-1:0] e_redir;
        e_valid = (in_ex_q.size() != 0);
        e_misp  = e_valid && (in_ex_q[0].pred != takenE);
        e_redir = takenE ? last_br.pt : last_br.p4;

        check("weE",          {63'd0, weE},         {63'd0, e_valid});
        check("waddrE",       {32'd0, waddrE},      {32'd0, last_br.pc});
        check("wdE",          {63'd0, wdE},         {63'd0, takenE});
        check("mispredictE",  {63'd0, mispredictE}, {63'd0, e_misp});
        check("redirectPcE",  {32'd0, redirectPcE}, {32'd0, e_redir});
        check("squashD",      {63'd0, squashD},     {63'd0, e_misp});
        check("branchCount",  {48'd0, branchCount},  64'(m_bc > 65535 ? 65535 : m_bc));
        check("mispredCount", {48'd0, mispredCount}, 64'(m_mc > 65535 ? 65535 : m_mc));
        check("s_weE",        {63'd0, s_weE},       {63'd0, e_valid});
        check("s_branchCount",  {60'd0, s_branchCount},  64'(m_bc > 15 ? 15 : m_bc));
        check("s_mispredCount", {60'd0, s_mispredCount}, 64'(m_mc > 15 ? 15 : m_mc));

        if (reset) begin
            in_ex_q.delete();
            last_br = '0;
            m_bc = 0;
            m_mc = 0;
        end else begin
            br_t nb;
            if (e_valid) begin
                m_bc = sat_inc(m_bc, 65535);
                if (e_misp) m_mc = sat_inc(m_mc, 65535);
                void'(in_ex_q.pop_front());
            end
            if (branchD && !flushE && !e_misp) begin
                nb.pred = predD;
                nb.pc   = pcD;
                nb.p4   = pcplus4D;
                nb.pt   = pcbranchD;
                in_ex_q.push_back(nb);
                last_br = nb;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic br, input logic pr, input logic [AW-1:0] pc,
                         input logic fl, input logic tk);
        @(posedge clk);
        #1;
        branchD   = br;
        predD     = pr;
        pcD       = pc;
        pcplus4D  = pc + 32'd4;
        pcbranchD = pc + 32'h40;
        flushE    = fl;
        takenE    = tk;
    endtask

    task automatic mid;
        @(negedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        reset = 1'b1;
        branchD = 0; predD = 0; pcD = '0; pcplus4D = '0; pcbranchD = '0;
        flushE = 0; takenE = 0;
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        reset = 1'b0;

        // idle after reset: everything zero
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0);
            mid();
            check("idle_we",    {63'd0, weE},          64'd0);
            check("idle_redir", {32'd0, redirectPcE},  64'd0);
            check("idle_bc",    {48'd0, branchCount},  64'd0);
        end

        // correct prediction, taken
        drive(1, 1, 32'h40, 0, 0);
        drive(0, 0, 32'h0, 0, 1);
        mid();
        check("t2_we",    {63'd0, weE},         64'd1);
        check("t2_waddr", {32'd0, waddrE},      64'h40);
        check("t2_wd",    {63'd0, wdE},         64'd1);
        check("t2_misp",  {63'd0, mispredictE}, 64'd0);
        drive(0, 0, 32'h0, 0, 0);
        mid();
        check("t2_bc", {48'd0, branchCount},  64'd1);
        check("t2_mc", {48'd0, mispredCount}, 64'd0);

        // mispredict not taken, younger branch in Decode is dropped
        drive(1, 1, 32'h40, 0, 0);
        drive(1, 1, 32'h100, 0, 0);
        mid();
        check("t3_misp",   {63'd0, mispredictE}, 64'd1);
        check("t3_redir",  {32'd0, redirectPcE}, 64'h44);
        check("t3_squash", {63'd0, squashD},     64'd1);
        drive(0, 0, 32'h0, 0, 0);
        mid();
        check("t3_we", {63'd0, weE},          64'd0);
        check("t3_bc", {48'd0, branchCount},  64'd2);
        check("t3_mc", {48'd0, mispredCount}, 64'd1);

        // stall: branch held three cycles, flushed for the first two
        pulses = 0;
        drive(1, 0, 32'h200, 1, 0); mid(); pulses += int'(weE);
        drive(1, 0, 32'h200, 1, 0); mid(); pulses += int'(weE);
        drive(1, 0, 32'h200, 0, 0); mid(); pulses += int'(weE);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 0, 0); mid(); pulses += int'(weE);
        end
        check("t4_pulses", 64'(pulses), 64'd1);
        check("t4_bc", {48'd0, branchCount}, 64'd3);

        // reset in the cycle a branch resolves
        drive(1, 1, 32'h300, 0, 0);
        drive(0, 0, 32'h0, 0, 1);
        reset = 1'b1;
        drive(0, 0, 32'h0, 0, 0);
        reset = 1'b0;
        mid();
        check("t5_we", {63'd0, weE},          64'd0);
        check("t5_bc", {48'd0, branchCount},  64'd0);
        check("t5_mc", {48'd0, mispredCount}, 64'd0);

        // saturation: 20 mispredicted branches
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 32'h1000 + 32'(i * 4), 0, 0);
            drive(0, 0, 32'h0, 0, 0);
        end
        drive(0, 0, 32'h0, 0, 0);
        mid();
        check("t6_sbc", {60'd0, s_branchCount},  64'd15);
        check("t6_smc", {60'd0, s_mispredCount}, 64'd15);
        check("t6_bc",  {48'd0, branchCount},    64'd20);
        check("t6_mc",  {48'd0, mispredCount},   64'd20);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  32'($urandom) & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            reset = ($urandom_range(0, 199) == 0);
        end
        drive(0, 0, 32'h0, 0, 0);
        reset = 1'b0;
        mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution and predictor-update unit for the pipelined MIPS core. It is the writer side of the one-bit branch prediction memory: it captures each predicted branch leaving Decode and resolves it in Execute against the actual outcome. It then issues the predictor write (address, taken bit, write strobe), the misprediction redirect PC and the wrong-path squash, and keeps saturating branch/mispredict counters.

## Interface
- AW, 32, PC/address width
- CW, 16, width of each performance counter

- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- branchD  in  1  Decode holds a conditional branch
- predD  in  1  prediction read for pcD (1 = predicted taken)
- pcD  in  AW  PC of the Decode instruction
- pcplus4D  in  AW  fall-through PC
- pcbranchD  in  AW  branch target PC
- flushE  in  1  hazard unit bubbles Execute (load-use/branch stall)
- takenE  in  1  actual branch outcome computed in Execute
- weE  out  1  predictor write strobe
- waddrE  out  AW  predictor write address (= captured pcD)
- wdE  out  1  predictor write data (= takenE)
- mispredictE  out  1  captured prediction ≠ takenE
- redirectPcE  out  AW  correct next PC, valid when mispredictE
- squashD  out  1  kill the wrong-path instruction now in Fetch/Decode
- branchCount  out  CW  resolved branches
- mispredCount  out  CW  mispredicted branches

## Operation
- E-stage register set: validE, predE, pcE, pcplus4E, pcbranchE.
- Capture rule each edge: validE ← branchD & ~flushE & ~mispredictE; data fields load only when the capture term is 1, otherwise they hold.
- The hazard unit raises flushE while stalling, so the branch stays in Decode and is captured on the cycle the stall releases. It must never be captured twice.
- A mispredict in Execute kills the younger Decode instruction, so a branch in Decode that cycle is never captured.
- Combinational from the E registers:
  - weE = validE
  - waddrE = pcE
  - wdE = takenE
  - mispredictE = validE & (predE ^ takenE)
  - redirectPcE = takenE ? pcbranchE : pcplus4E
  - squashD = mispredictE
- Counters: branchCount += 1 when validE; mispredCount += 1 when mispredictE. Both saturate at 2^CW−1 and never wrap.
- mispredCount ≤ branchCount always.

## Timing
- Reset: validE=0, predE=0, pcE=pcplus4E=pcbranchE=0, both counters 0.
  - Hence weE=0, mispredictE=0, squashD=0, redirectPcE=0, waddrE=0.
- A reset asserted while a branch sits in Execute discards it with no predictor write and no count.
- Latency:
  - A branch in Decode at edge N is resolved during cycle N+1.
  - The predictor write and counters commit at edge N+2.
  - The fetch redirect takes effect at edge N+2.
- Back-to-back branches in Decode on consecutive cycles resolve on consecutive cycles when all predictions are correct.
- Simultaneous events:
  - flushE and branchD together: no capture, validE=0 next cycle.
  - mispredictE and branchD together: no capture.
  - flushE and mispredictE together: no capture; the mispredict outputs are still driven.
- No valid branch in Execute means all strobes are 0 and redirectPcE is don't-care but deterministic per the formula above.

## Test plan
- Reset then idle 5 cycles: every output stays 0, both counters stay 0.
- Correct prediction, taken:
  - Stimulus: branchD=1, predD=1, pcD=0x40, pcplus4D=0x44, pcbranchD=0x80; next cycle takenE=1.
  - Response: weE=1, waddrE=0x40, wdE=1, mispredictE=0; branchCount=1, mispredCount=0.
- Mispredict, not taken:
  - Stimulus: same branch with predD=1, takenE=0, and a second branch in Decode during resolution.
  - Response: mispredictE=1, redirectPcE=0x44, squashD=1; the second branch is not captured (validE=0 next cycle); mispredCount=1.
- Stall:
  - Stimulus: branchD held 3 cycles with flushE=1 for the first 2.
  - Response: exactly one capture, on the third edge; exactly one weE pulse; branchCount=1.
- Saturation:
  - Stimulus: CW=4, 20 consecutive mispredicted branches.
  - Response: both counters stick at 15.
- Reset mid-operation:
  - Stimulus: reset asserted in the cycle a branch resolves.
  - Response: next cycle weE=0, both counters 0, and no predictor write has occurred.
